// File: rtl/victim_wbuf.sv
// Victim/write-back buffer: FIFO of evicted lines and uncached stores, drained
// as AXI write bursts, with a combinational lookup so refills see queued data.
module victim_wbuf #(
  parameter int DEPTH      = 4,
  parameter int LINE_WORDS = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic                         push_uncache,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] push_line,
  input  logic [DATA_W/8-1:0]          push_strb,
  input  logic [ADDR_W-1:0]            lk_addr,
  output logic                         lk_hit,
  output logic [LINE_WORDS*DATA_W-1:0] lk_line,
  output logic                         awvalid,
  input  logic                         awready,
  output logic [ADDR_W-1:0]            awaddr,
  output logic [7:0]                   awlen,
  output logic [2:0]                   awsize,
  output logic                         wvalid,
  input  logic                         wready,
  output logic [DATA_W-1:0]            wdata,
  output logic [DATA_W/8-1:0]          wstrb,
  output logic                         wlast,
  input  logic                         bvalid,
  output logic                         bready,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OFF_W  = $clog2(LINE_WORDS * STRB_W);
  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [7:0]        LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t              state_reg;
  logic [BEAT_W-1:0]   beat_reg;
  logic [PTR_W-1:0]    head_reg;
  logic [PTR_W-1:0]    tail_reg;
  logic [CNT_W-1:0]    count_reg;

  logic                valid_reg [DEPTH];
  logic                unc_reg   [DEPTH];
  logic [ADDR_W-1:0]   addr_reg  [DEPTH];
  logic [LINE_W-1:0]   line_reg  [DEPTH];
  logic [STRB_W-1:0]   strb_reg  [DEPTH];

  logic                push_fire;
  logic                pop_fire;
  logic                head_unc;
  logic [7:0]          head_len;
  logic [LINE_W-1:0]   head_line;
  logic [BEAT_W-1:0]   word_sel;
  logic [DEPTH-1:0]    match;
  logic [PTR_W-1:0]    lk_idx;
  logic                unused_lk_bits;

  assign push_ready = (count_reg != CNT_W'(DEPTH));
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = (state_reg == S_B) && bvalid;
  assign count      = count_reg;
  assign empty      = (count_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_reg[i] <= 1'b0;
        unc_reg[i]   <= 1'b0;
        addr_reg[i]  <= '0;
        line_reg[i]  <= '0;
        strb_reg[i]  <= '0;
      end
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_fire) begin
        valid_reg[tail_reg] <= 1'b1;
        unc_reg[tail_reg]   <= push_uncache;
        // Lines are stored line-aligned so awaddr is a clean burst start.
        addr_reg[tail_reg]  <= push_uncache ? push_addr : (push_addr & LINE_MASK);
        line_reg[tail_reg]  <= push_line;
        strb_reg[tail_reg]  <= push_uncache ? push_strb : {STRB_W{1'b1}};
        tail_reg            <= tail_reg + 1'b1;
      end
      if (pop_fire) begin
        valid_reg[head_reg] <= 1'b0;
        head_reg            <= head_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      beat_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (count_reg != '0) state_reg <= S_AW;
        S_AW: if (awready) begin
          state_reg <= S_W;
          beat_reg  <= '0;
        end
        S_W: if (wready) begin
          beat_reg <= beat_reg + 1'b1;
          if (wlast) state_reg <= S_B;
        end
        S_B: if (bvalid) state_reg <= (count_reg > CNT_W'(1)) ? S_AW : S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign head_unc  = unc_reg[head_reg];
  assign head_len  = head_unc ? 8'd0 : LINE_LEN;
  assign head_line = line_reg[head_reg];
  assign word_sel  = head_unc ? '0 : beat_reg;

  assign awvalid = (state_reg == S_AW);
  assign awaddr  = awvalid ? addr_reg[head_reg] : '0;
  assign awlen   = head_len;
  assign awsize  = 3'($clog2(STRB_W));
  assign wvalid  = (state_reg == S_W);
  assign wdata   = wvalid ? head_line[word_sel*DATA_W +: DATA_W] : '0;
  assign wstrb   = wvalid ? strb_reg[head_reg] : '0;
  assign wlast   = wvalid && (8'(beat_reg) == head_len);
  assign bready  = (state_reg == S_B);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && !unc_reg[gi] &&
                       (addr_reg[gi][ADDR_W-1:OFF_W] == lk_addr[ADDR_W-1:OFF_W]);
  end

  // Walk from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    lk_hit  = 1'b0;
    lk_line = '0;
    lk_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_reg + PTR_W'(i);
      if (match[lk_idx]) begin
        lk_hit  = 1'b1;
        lk_line = line_reg[lk_idx];
      end
    end
  end

  assign unused_lk_bits = ^lk_addr[OFF_W-1:0];

endmodule

// File: tb/tb_victim_wbuf.sv
// Directed + randomized bench for victim_wbuf with a queue-based reference
// model and a randomly stalling AXI write slave.
module tb_victim_wbuf;
  localparam int DEPTH  = 4;
  localparam int LW     = 16;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int LINE_W = LW * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push_valid, push_ready, push_uncache;
  logic [AW-1:0] push_addr, lk_addr, awaddr;
  logic [LINE_W-1:0] push_line, lk_line;
  logic [DW/8-1:0] push_strb, wstrb;
  logic lk_hit, awvalid, awready, wvalid, wready, wlast, bvalid, bready, empty;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic [DW-1:0] wdata;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  victim_wbuf #(.DEPTH(DEPTH), .LINE_WORDS(LW), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_uncache(push_uncache),
    .push_addr(push_addr), .push_line(push_line), .push_strb(push_strb),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_line(lk_line),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .count(count), .empty(empty)
  );

  typedef struct {
    logic              unc;
    logic [AW-1:0]     addr;
    logic [LINE_W-1:0] line;
    logic [DW/8-1:0]   strb;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  int n_vec = 0, n_err = 0;
  int hold_aw = 0, rand_en = 0;
  int ph = 0, sl_beat = 0, sl_dly = 0, b_cnt = 0;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: bound expired or unexpected event", tag);
  endtask

  function automatic int rnd();
    return (rand_en != 0) ? int'($urandom_range(0, 5)) : 0;
  endfunction

  function automatic logic [LINE_W-1:0] rline();
    logic [LINE_W-1:0] r;
    for (int k = 0; k < LW; k++) r[k*DW +: DW] = $urandom;
    return r;
  endfunction

  // Youngest queued full line whose line address matches wins.
  function automatic logic [LINE_W:0] model_lk(input logic [AW-1:0] a);
    for (int i = q.size() - 1; i >= 0; i--)
      if (!q[i].unc && q[i].addr[AW-1:6] == a[AW-1:6]) return {1'b1, q[i].line};
    return '0;
  endfunction

  // AXI write slave: decisions and output sampling on the falling edge.
  initial begin
    logic [7:0] len;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      if (rst) begin
        ph = 0; sl_beat = 0; sl_dly = 0;
      end else if (ph == 0) begin
        if (awvalid && hold_aw == 0) begin
          if (sl_dly > 0) sl_dly--;
          else if (q.size() == 0) fail("aw_without_entry");
          else begin
            cur = q[0];
            chk("awaddr", awaddr, cur.unc ? cur.addr : {cur.addr[AW-1:6], 6'b0});
            chk("awlen", awlen, cur.unc ? 8'd0 : 8'd15);
            chk("awsize", awsize, 3'd2);
            chk("wvalid_before_aw", wvalid, 1'b0);
            awready = 1'b1;
            ph = 1; sl_beat = 0; sl_dly = rnd();
          end
        end
      end else if (ph == 1) begin
        if (wvalid) begin
          if (sl_dly > 0) sl_dly--;
          else begin
            len = cur.unc ? 8'd0 : 8'd15;
            chk($sformatf("wdata_b%0d", sl_beat), wdata,
                cur.unc ? cur.line[DW-1:0] : cur.line[sl_beat*DW +: DW]);
            chk("wstrb", wstrb, cur.unc ? cur.strb : 4'hF);
            chk($sformatf("wlast_b%0d", sl_beat), wlast, sl_beat == int'(len));
            wready = 1'b1;
            if (sl_beat == int'(len)) ph = 2;
            sl_beat++;
            sl_dly = rnd();
          end
        end
      end else begin
        if (sl_dly > 0) sl_dly--;
        else begin
          chk("bready", bready, 1'b1);
          bvalid = 1'b1;
          void'(q.pop_front());
          b_cnt++;
          ph = 0;
          sl_dly = rnd();
        end
      end
    end
  end

  task automatic do_push(input logic unc, input logic [AW-1:0] a,
                         input logic [LINE_W-1:0] l, input logic [DW/8-1:0] s);
    int t = 0;
    @(negedge clk);
    push_valid = 1'b1; push_uncache = unc; push_addr = a; push_line = l; push_strb = s;
    while (!push_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!push_ready) fail("push_timeout");
    else q.push_back('{unc, a, l, s});
    @(posedge clk);
    #1 push_valid = 1'b0;
  endtask

  task automatic chk_lk(input string tag, input logic [AW-1:0] a);
    logic [LINE_W:0] e;
    @(posedge clk);
    #1 lk_addr = a;
    #1 e = model_lk(a);
    chk({tag, "_hit"}, lk_hit, e[LINE_W]);
    chk({tag, "_line"}, lk_line, e[LINE_W-1:0]);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    do begin
      @(posedge clk);
      #2 t++;
    end while (!(q.size() == 0 && empty) && t < 3000);
    if (!(q.size() == 0 && empty)) fail({tag, "_drain_timeout"});
    chk({tag, "_count"}, count, 0);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, b0;
    logic [LINE_W-1:0] l, x, y;
    logic [AW-1:0] a;
    logic u;
    push_valid = 1'b0; push_uncache = 1'b0; push_addr = '0; push_line = '0;
    push_strb = '0; lk_addr = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_lk_hit", lk_hit, 1'b0);
    chk("rst_push_ready", push_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_lk_line", lk_line, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;

    // Single full line, slave always ready.
    for (int k = 0; k < LW; k++) l[k*DW +: DW] = 32'hA000_0000 + k;
    do_push(1'b0, 32'h0000_1040, l, 4'hF);
    lk_addr = 32'h0000_1040;
    #1;
    chk("t1_lk_hit_t1", lk_hit, 1'b1);
    chk("t1_count_t1", count, 1);
    chk("t1_empty_t1", empty, 1'b0);
    chk("t1_awvalid_t1", awvalid, 1'b0);
    @(posedge clk);
    #1 chk("t1_awvalid_t2", awvalid, 1'b1);
    wait_idle("t1");

    // Uncached single-word store.
    l = rline();
    l[DW-1:0] = 32'h0000_00AB;
    do_push(1'b1, 32'h1FE0_01F8, l, 4'b0001);
    chk_lk("t2_lk_uncached", 32'h1FE0_01F8);
    wait_idle("t2");

    // Fill with AW stalled, then release.
    hold_aw = 1;
    for (int i = 0; i < DEPTH; i++) do_push(1'b0, 32'h5000 + i * 64, rline(), 4'hF);
    @(posedge clk);
    #2;
    chk("t3_full_ready", push_ready, 1'b0);
    chk("t3_full_count", count, 4);
    @(negedge clk);
    push_valid = 1'b1; push_uncache = 1'b0; push_addr = 32'h6000; push_line = rline();
    @(posedge clk);
    #1 push_valid = 1'b0;
    #1;
    chk("t3_5th_count", count, 4);
    chk("t3_5th_ready", push_ready, 1'b0);
    chk_lk("t3_lk", 32'h5080);
    hold_aw = 0;
    b0 = b_cnt;
    t = 0;
    while (b_cnt == b0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (b_cnt == b0) fail("t3_first_b_timeout");
    #2 chk("t3_ready_after_b", push_ready, 1'b1);
    wait_idle("t3");

    // Duplicate lines: the younger one forwards.
    hold_aw = 1;
    x = rline();
    y = rline();
    do_push(1'b0, 32'h2000, x, 4'hF);
    do_push(1'b0, 32'h2000, y, 4'hF);
    chk_lk("t4_dup", 32'h2024);
    chk("t4_line_is_y", lk_line, y);
    chk_lk("t4_miss", 32'h3000);
    hold_aw = 0;
    wait_idle("t4");
    chk_lk("t4_after_drain", 32'h2000);

    // Random mix with random slave stalls; wraps the pointers.
    rand_en = 1;
    for (int i = 0; i < 10; i++) begin
      u = ($urandom_range(0, 3) == 0);
      a = 32'h8000 + $urandom_range(0, 3) * 64 + (u ? $urandom_range(0, 15) * 4 : $urandom_range(0, 63));
      do_push(u, a, rline(), u ? 4'($urandom_range(1, 15)) : 4'hF);
      chk_lk($sformatf("t5_lk%0d", i), 32'h8000 + $urandom_range(0, 3) * 64);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle("t5");
    rand_en = 0;

    // Reset in the middle of a burst.
    do_push(1'b0, 32'h9000, rline(), 4'hF);
    t = 0;
    while (!(ph == 1 && sl_beat == 7) && t < 200) begin
      @(posedge clk);
      #2 t++;
    end
    if (!(ph == 1 && sl_beat == 7)) fail("t6_beat7_timeout");
    rst = 1'b1;
    lk_addr = 32'h9000;
    #1;
    chk("t6_awvalid", awvalid, 1'b0);
    chk("t6_wvalid", wvalid, 1'b0);
    chk("t6_bready", bready, 1'b0);
    chk("t6_wlast", wlast, 1'b0);
    chk("t6_empty", empty, 1'b1);
    chk("t6_lk_hit", lk_hit, 1'b0);
    repeat (2) @(posedge clk);
    q.delete();
    #2 rst = 1'b0;
    do_push(1'b0, 32'hA040, rline(), 4'hF);
    wait_idle("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
